// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: reset / NMI / IRQ / BRK entry sequencer for the top8227 core.
//
// Synchronises the asynchronous NMI and IRQ pins, arbitrates between interrupt sources
// (NMI > BRK > IRQ) at instruction boundaries, and hands the winner to the control state
// machine through a serviceReq / serviceAck handshake. After reset deasserts, resetActive
// is held for RESET_CYCLES cycles and then a reset service request is issued.
//
// Optional feature macro: NMI_DEBOUNCE_EN
//   When defined, the synchronised NMI level passes through a debouncer that only follows
//   the pin after DEBOUNCE_CYCLES consecutive differing samples. The edge detector then
//   runs on the debounced level.
//
// Ports:
//   clk                  in   system clock, all state on posedge
//   nrst                 in   synchronous active-low reset
//   nonMaskableInterrupt in   async NMI pin, rising edge requests NMI
//   interruptRequest     in   async IRQ pin, active-high level
//   iFlag                in   processor I bit, 1 masks IRQ
//   instrBoundary        in   pulse on the last cycle of an instruction
//   brkOpcode            in   with instrBoundary: next opcode is BRK
//   serviceAck           in   pulse: state machine has loaded the vector
//   serviceReq           out  interrupt sequence requested, held until serviceAck
//   intType              out  00 none, 01 reset, 10 NMI, 11 IRQ/BRK
//   isBrk                out  IRQ/BRK entry caused by BRK
//   vectorAddr           out  FFFC reset, FFFA NMI, FFFE IRQ/BRK, 0000 when idle
//   setIFlag             out  pulse in the cycle after serviceAck
//   resetActive          out  high during the reset countdown

module interrupt_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RESET_CYCLES    = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        nonMaskableInterrupt,
    input  logic        interruptRequest,
    input  logic        iFlag,
    input  logic        instrBoundary,
    input  logic        brkOpcode,
    input  logic        serviceAck,
    output logic        serviceReq,
    output logic [1:0]  intType,
    output logic        isBrk,
    output logic [15:0] vectorAddr,
    output logic        setIFlag,
    output logic        resetActive
);

    localparam int unsigned CntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [1:0] StResetSeq = 2'd0;
    localparam logic [1:0] StIdle     = 2'd1;
    localparam logic [1:0] StPending  = 2'd2;
    localparam logic [1:0] StService  = 2'd3;

    localparam logic [1:0] TypeNone  = 2'b00;
    localparam logic [1:0] TypeReset = 2'b01;
    localparam logic [1:0] TypeNmi   = 2'b10;
    localparam logic [1:0] TypeIrq   = 2'b11;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset
        $error("RESET_CYCLES must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [SYNC_STAGES-1:0] irq_sync_q;
    logic                   nmi_level;
    logic                   nmi_prev_q;
    logic                   nmi_edge;
    logic                   irq_live;
    logic                   nmi_latch_q, nmi_latch_d;
    // Edge seen while an NMI is being served; becomes the latch value on that ack.
    logic                   nmi_again_q, nmi_again_d;
    logic [1:0]             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic [1:0]             type_q, type_d;
    logic                   brk_q, brk_d;
    logic [15:0]            vec_q, vec_d;
    logic                   setif_q, setif_d;

    // Pin synchronisers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            nmi_sync_q <= '0;
            irq_sync_q <= '0;
        end else begin
            nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nonMaskableInterrupt};
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], interruptRequest};
        end
    end

`ifdef NMI_DEBOUNCE_EN
    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            deb_q, deb_d;

    // Counts consecutive samples that disagree with the debounced level.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (nmi_sync_q[SYNC_STAGES-1] != deb_q) begin
            if (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = nmi_sync_q[SYNC_STAGES-1];
            end else begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign nmi_level = deb_q;
`else
    assign nmi_level = nmi_sync_q[SYNC_STAGES-1];
`endif

    assign nmi_edge = nmi_level & ~nmi_prev_q;
    assign irq_live = irq_sync_q[SYNC_STAGES-1] & ~iFlag;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        type_d      = type_q;
        brk_d       = brk_q;
        vec_d       = vec_q;
        setif_d     = 1'b0;
        nmi_latch_d = nmi_latch_q | nmi_edge;
        nmi_again_d = nmi_again_q;

        unique case (state_q)
            StResetSeq: begin
                // Reset service is issued without waiting for an instruction boundary.
                if (cnt_q == '0) begin
                    state_d = StService;
                    req_d   = 1'b1;
                    type_d  = TypeReset;
                    brk_d   = 1'b0;
                    vec_d   = 16'hFFFC;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StIdle, StPending: begin
                if (instrBoundary && nmi_latch_q) begin
                    state_d = StService;
                    req_d   = 1'b1;
                    type_d  = TypeNmi;
                    brk_d   = 1'b0;
                    vec_d   = 16'hFFFA;
                end else if (instrBoundary && brkOpcode) begin
                    state_d = StService;
                    req_d   = 1'b1;
                    type_d  = TypeIrq;
                    brk_d   = 1'b1;
                    vec_d   = 16'hFFFE;
                end else if (instrBoundary && irq_live) begin
                    state_d = StService;
                    req_d   = 1'b1;
                    type_d  = TypeIrq;
                    brk_d   = 1'b0;
                    vec_d   = 16'hFFFE;
                end else if (nmi_latch_d || irq_live) begin
                    state_d = StPending;
                end else begin
                    state_d = StIdle;
                end
            end

            StService: begin
                if (type_q == TypeNmi) begin
                    nmi_again_d = nmi_again_q | nmi_edge;
                end
                if (serviceAck) begin
                    req_d   = 1'b0;
                    type_d  = TypeNone;
                    brk_d   = 1'b0;
                    vec_d   = 16'h0000;
                    setif_d = 1'b1;
                    // Serving an NMI consumes the latch, but an edge in the ack cycle or
                    // earlier in this service is kept for the next boundary.
                    if (type_q == TypeNmi) begin
                        nmi_latch_d = nmi_again_q | nmi_edge;
                    end
                    nmi_again_d = 1'b0;
                    state_d     = nmi_latch_d ? StPending : StIdle;
                end
            end

            default: state_d = StResetSeq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StResetSeq;
            cnt_q       <= CntW'(RESET_CYCLES - 1);
            req_q       <= 1'b0;
            type_q      <= TypeNone;
            brk_q       <= 1'b0;
            vec_q       <= 16'h0000;
            setif_q     <= 1'b0;
            nmi_prev_q  <= 1'b0;
            nmi_latch_q <= 1'b0;
            nmi_again_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            type_q      <= type_d;
            brk_q       <= brk_d;
            vec_q       <= vec_d;
            setif_q     <= setif_d;
            nmi_prev_q  <= nmi_level;
            nmi_latch_q <= nmi_latch_d;
            nmi_again_q <= nmi_again_d;
        end
    end

    assign serviceReq  = req_q;
    assign intType     = type_q;
    assign isBrk       = brk_q;
    assign vectorAddr  = vec_q;
    assign setIFlag    = setif_q;
    assign resetActive = (state_q == StResetSeq);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed scenarios plus randomized stimulus checked
// against a flag-level reference model of the sequencing rules.
module tb_interrupt_sequencer;

    localparam int S  = 2;
    localparam int RC = 7;
    localparam int DC = 16;
`ifdef NMI_DEBOUNCE_EN
    localparam int EdgeTicks = S + DC;
`else
    localparam int EdgeTicks = S;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0, nmi = 1'b0, irq = 1'b0, iflag = 1'b0;
    logic bnd = 1'b0, brk = 1'b0, ack = 1'b0;
    logic        serviceReq;
    logic [1:0]  intType;
    logic        isBrk;
    logic [15:0] vectorAddr;
    logic        setIFlag;
    logic        resetActive;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    interrupt_sequencer #(
        .SYNC_STAGES(S),
        .RESET_CYCLES(RC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .nonMaskableInterrupt(nmi),
        .interruptRequest(irq),
        .iFlag(iflag),
        .instrBoundary(bnd),
        .brkOpcode(brk),
        .serviceAck(ack),
        .serviceReq(serviceReq),
        .intType(intType),
        .isBrk(isBrk),
        .vectorAddr(vectorAddr),
        .setIFlag(setIFlag),
        .resetActive(resetActive)
    );

    // Reference model: what is being served, what NMI is owed, and pin samples in flight.
    bit       m_in_reset = 1'b1;
    int       m_reset_left = RC - 1;
    bit       m_serving, m_brk, m_setif, m_nmi_pend, m_nmi_again, m_prev, m_deb;
    bit [1:0] m_type;
    int       m_dcnt;
    bit [1:0] m_pipe[$];

    function automatic bit [15:0] exp_vec(bit [1:0] t);
        case (t)
            2'b01:   return 16'hFFFC;
            2'b10:   return 16'hFFFA;
            2'b11:   return 16'hFFFE;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step();
        bit [1:0] lvl;
        bit nmi_lvl, nmi_edge, irq_ok;
        if (!nrst) begin
            m_in_reset = 1; m_reset_left = RC - 1; m_serving = 0; m_type = 0; m_brk = 0;
            m_setif = 0; m_nmi_pend = 0; m_nmi_again = 0; m_prev = 0; m_deb = 0; m_dcnt = 0;
            m_pipe.delete();
            for (int i = 0; i < S; i++) m_pipe.push_back(2'b00);
            return;
        end
        lvl = m_pipe.pop_front();
        m_pipe.push_back({nmi, irq});
`ifdef NMI_DEBOUNCE_EN
        nmi_lvl = m_deb;
        if (lvl[1] != m_deb) begin
            m_dcnt++;
            if (m_dcnt == DC) begin
                m_deb = lvl[1];
                m_dcnt = 0;
            end
        end else begin
            m_dcnt = 0;
        end
`else
        nmi_lvl = lvl[1];
`endif
        nmi_edge = nmi_lvl && !m_prev;
        m_prev = nmi_lvl;
        irq_ok = lvl[0] && !iflag;
        m_setif = 0;
        if (m_in_reset) begin
            if (m_reset_left == 0) begin
                m_in_reset = 0; m_serving = 1; m_type = 2'b01; m_brk = 0;
            end else begin
                m_reset_left--;
            end
            m_nmi_pend |= nmi_edge;
        end else if (m_serving) begin
            if (ack) begin
                m_serving = 0; m_setif = 1;
                if (m_type == 2'b10) m_nmi_pend = m_nmi_again | nmi_edge;
                else m_nmi_pend |= nmi_edge;
                m_nmi_again = 0; m_type = 0; m_brk = 0;
            end else begin
                m_nmi_pend |= nmi_edge;
                if (m_type == 2'b10) m_nmi_again |= nmi_edge;
            end
        end else begin
            if (bnd && m_nmi_pend) begin
                m_serving = 1; m_type = 2'b10; m_brk = 0;
            end else if (bnd && brk) begin
                m_serving = 1; m_type = 2'b11; m_brk = 1;
            end else if (bnd && irq_ok) begin
                m_serving = 1; m_type = 2'b11; m_brk = 0;
            end
            m_nmi_pend |= nmi_edge;
        end
    endtask

    // Inputs change at the negedge; the DUT samples them on the posedge and outputs
    // are observed at the following negedge.
    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        nrst = 0;
        tick(3);
        vectors++;
        if ({serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive} !== {1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: got req=%b type=%b brk=%b vec=%h setI=%b ract=%b, expected 0 00 0 0000 0 1",
                     serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive);
        end
        nrst = 1;
        for (int i = 0; i < RC; i++) begin
            vectors++;
            if (resetActive !== 1'b1 || serviceReq !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_countdown[%0d]: got ract=%b req=%b, expected ract=1 req=0",
                         i, resetActive, serviceReq);
            end
            tick();
        end
        vectors++;
        if ({serviceReq, intType, vectorAddr, resetActive} !== {1'b1, 2'b01, 16'hFFFC, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_service: got req=%b type=%b vec=%h ract=%b, expected 1 01 fffc 0",
                     serviceReq, intType, vectorAddr, resetActive);
        end
        ack = 1; tick(); ack = 0;
        vectors++;
        if (serviceReq !== 1'b0 || setIFlag !== 1'b1 || vectorAddr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_ack: got req=%b setI=%b vec=%h, expected 0 1 0000",
                     serviceReq, setIFlag, vectorAddr);
        end
        tick();
    endtask

    task automatic test_irq();
        irq = 1; iflag = 0;
        tick(S + 1);
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_no_boundary: got req=%b, expected 0", serviceReq);
        end
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr, isBrk} !== {1'b1, 2'b11, 16'hFFFE, 1'b0}) begin
            miscompares++;
            $display("FAIL irq_entry: got req=%b type=%b vec=%h brk=%b, expected 1 11 fffe 0",
                     serviceReq, intType, vectorAddr, isBrk);
        end
        irq = 0; bnd = 1; tick(2); bnd = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr} !== {1'b1, 2'b11, 16'hFFFE}) begin
            miscompares++;
            $display("FAIL irq_hold: got req=%b type=%b vec=%h, expected 1 11 fffe",
                     serviceReq, intType, vectorAddr);
        end
        ack = 1; tick(); ack = 0;
        vectors++;
        if (serviceReq !== 1'b0 || setIFlag !== 1'b1 || intType !== 2'b00) begin
            miscompares++;
            $display("FAIL irq_ack: got req=%b setI=%b type=%b, expected 0 1 00",
                     serviceReq, setIFlag, intType);
        end
        tick();
        vectors++;
        if (setIFlag !== 1'b0) begin
            miscompares++;
            $display("FAIL setif_pulse: got setI=%b one cycle later, expected 0", setIFlag);
        end
        tick(S);
    endtask

    task automatic test_masked_and_brk();
        irq = 1; iflag = 1;
        tick(S + 1);
        for (int i = 0; i < 3; i++) begin
            bnd = 1; tick(); bnd = 0; tick();
            vectors++;
            if (serviceReq !== 1'b0) begin
                miscompares++;
                $display("FAIL irq_masked[%0d]: got req=%b, expected 0", i, serviceReq);
            end
        end
        bnd = 1; brk = 1; tick(); bnd = 0; brk = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr, isBrk} !== {1'b1, 2'b11, 16'hFFFE, 1'b1}) begin
            miscompares++;
            $display("FAIL brk_entry: got req=%b type=%b vec=%h brk=%b, expected 1 11 fffe 1",
                     serviceReq, intType, vectorAddr, isBrk);
        end
        irq = 0; iflag = 0;
        ack = 1; tick(); ack = 0;
        tick(S + 1);
    endtask

    task automatic test_nmi_priority();
        nmi = 1; irq = 1; iflag = 0;
        tick(EdgeTicks + 2);
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL nmi_waits_boundary: got req=%b, expected 0", serviceReq);
        end
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr} !== {1'b1, 2'b10, 16'hFFFA}) begin
            miscompares++;
            $display("FAIL nmi_over_irq: got req=%b type=%b vec=%h, expected 1 10 fffa",
                     serviceReq, intType, vectorAddr);
        end
        ack = 1; tick(); ack = 0;
        tick();
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr} !== {1'b1, 2'b11, 16'hFFFE}) begin
            miscompares++;
            $display("FAIL irq_after_nmi: got req=%b type=%b vec=%h, expected 1 11 fffe",
                     serviceReq, intType, vectorAddr);
        end
        irq = 0; nmi = 0;
        ack = 1; tick(); ack = 0;
        tick(EdgeTicks + 2);
    endtask

    task automatic test_nmi_at_ack();
        nmi = 1; tick(EdgeTicks + 2); nmi = 0; tick(EdgeTicks + 2);
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType} !== {1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL nmi_first: got req=%b type=%b, expected 1 10", serviceReq, intType);
        end
        // New edge timed to reach the edge detector exactly with the ack.
        nmi = 1; tick(EdgeTicks);
        ack = 1; tick(); ack = 0;
        tick(2);
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL nmi_ack_idle: got req=%b, expected 0", serviceReq);
        end
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType, vectorAddr} !== {1'b1, 2'b10, 16'hFFFA}) begin
            miscompares++;
            $display("FAIL nmi_second: got req=%b type=%b vec=%h, expected 1 10 fffa",
                     serviceReq, intType, vectorAddr);
        end
        ack = 1; tick(); ack = 0;
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL nmi_no_third: got req=%b, expected 0", serviceReq);
        end
        nmi = 0; tick(EdgeTicks + 2);
    endtask

    task automatic test_reset_mid_service();
        irq = 1; tick(S + 1);
        bnd = 1; tick(); bnd = 0;
        nrst = 0; tick(); nrst = 1; irq = 0;
        vectors++;
        if ({serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive} !== {1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid_service: got req=%b type=%b brk=%b vec=%h setI=%b ract=%b, expected 0 00 0 0000 0 1",
                     serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive);
        end
        tick(RC);
        vectors++;
        if ({serviceReq, intType} !== {1'b1, 2'b01}) begin
            miscompares++;
            $display("FAIL reset_resume: got req=%b type=%b, expected 1 01", serviceReq, intType);
        end
        ack = 1; tick(); ack = 0; tick();
    endtask

`ifdef NMI_DEBOUNCE_EN
    task automatic test_debounce();
        nmi = 1; tick(5); nmi = 0; tick(40);
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL debounce_glitch: got req=%b, expected 0", serviceReq);
        end
        nmi = 1; tick(20); nmi = 0; tick(40);
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if ({serviceReq, intType} !== {1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL debounce_pulse: got req=%b type=%b, expected 1 10", serviceReq, intType);
        end
        ack = 1; tick(); ack = 0;
        bnd = 1; tick(); bnd = 0;
        vectors++;
        if (serviceReq !== 1'b0) begin
            miscompares++;
            $display("FAIL debounce_single: got req=%b, expected 0", serviceReq);
        end
    endtask
`endif

    task automatic test_random();
`ifdef NMI_DEBOUNCE_EN
        int nmi_flip = 40;
`else
        int nmi_flip = 10;
`endif
        for (int i = 0; i < 3000; i++) begin
            nrst  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, nmi_flip - 1) == 0) nmi = ~nmi;
            if ($urandom_range(0, 5) == 0) irq = ~irq;
            iflag = $urandom_range(0, 1);
            bnd   = ($urandom_range(0, 3) == 0);
            brk   = ($urandom_range(0, 5) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            tick();
            vectors++;
            if ({serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive} !==
                {m_serving, m_type, m_brk, exp_vec(m_type), m_setif, m_in_reset}) begin
                miscompares++;
                $display("FAIL random[%0d]: got req=%b type=%b brk=%b vec=%h setI=%b ract=%b, expected %b %b %b %h %b %b",
                         i, serviceReq, intType, isBrk, vectorAddr, setIFlag, resetActive,
                         m_serving, m_type, m_brk, exp_vec(m_type), m_setif, m_in_reset);
            end
        end
        nrst = 1; bnd = 0; brk = 0; ack = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_irq();
        test_masked_and_brk();
        test_nmi_priority();
        test_nmi_at_ack();
        test_reset_mid_service();
`ifdef NMI_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
